pc_compute: RTL and testbench

//  Program-counter register and next-PC logic for the single-cycle RISC-V datapath.

---
 rtl/pc_compute.sv | 106 ++++++++++
 tb/tb_pc_compute.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_compute.sv
// Program counter register with next-PC selection: jump target, taken branch, or sequential step.
// Latency: one cycle. The new pc is visible after the rising edge that samples the inputs.
// Backpressure: none. There is no stall input, so the pc advances on every edge while reset is low.
//
// Ports:
//   sysclk        in   1     clock; all state changes on the rising edge
//   reset         in   1     asynchronous, active-high; forces pc to RESET_VECTOR at once
//   immediate     in   XLEN  sign-extended immediate from the immediate generator
//   s0            in   1     jump select: load {immediate[XLEN-1:1],1'b0}
//   branch        in   1     current instruction is a conditional branch
//   alu_zero      in   1     branch condition met
//   pc            out  XLEN  current program counter (registered)
//   pc_misaligned out  1     only when PC_MISALIGN_EN is defined: the last loaded pc has pc[1:0] != 0
//
// Optional feature macro: PC_MISALIGN_EN adds the registered pc_misaligned flag.
// The flag is informational only; pc still loads the misaligned value.
module pc_compute #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              PC_STEP      = 4
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic [XLEN-1:0] immediate,
  input  logic            s0,
  input  logic            branch,
  input  logic            alu_zero,
`ifdef PC_MISALIGN_EN
  output logic            pc_misaligned,
`endif
  output logic [XLEN-1:0] pc
);

  // Next-PC source, in priority order: jump beats taken branch beats sequential step.
  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2
  } pc_src_e;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  pc_src_e         pc_src;

  // Both adders work from the current registered pc. Carries out of the top bit are
  // discarded, so the arithmetic wraps modulo 2^XLEN.
  assign seq_target    = pc_q + STEP;
  assign branch_target = pc_q + immediate;

  // Bit 0 of a jump target is always cleared, as for JALR.
  assign jump_target   = {immediate[XLEN-1:1], 1'b0};

  always_comb begin
    pc_src = SRC_SEQ;
    if (s0) begin
      pc_src = SRC_JUMP;
    end else if (branch && alu_zero) begin
      pc_src = SRC_BRANCH;
    end
  end

  always_comb begin
    pc_d = seq_target;
    unique case (pc_src)
      SRC_JUMP:   pc_d = jump_target;
      SRC_BRANCH: pc_d = branch_target;
      SRC_SEQ:    pc_d = seq_target;
      default:    pc_d = seq_target;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

`ifdef PC_MISALIGN_EN
  // The flag follows the alignment of the value being loaded, so it changes on the
  // same edge as pc and clears on the first aligned load.
  logic misaligned_q;
  logic misaligned_d;

  assign misaligned_d = |pc_d[1:0];

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_pc_compute.sv
module tb_pc_compute;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [31:0] immediate;
  logic        s0;
  logic        branch;
  logic        alu_zero;
  logic [31:0] pc;
`ifdef PC_MISALIGN_EN
  logic        pc_misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  pc_compute #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0000_0000),
    .PC_STEP     (4)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .immediate    (immediate),
    .s0           (s0),
    .branch       (branch),
    .alu_zero     (alu_zero),
`ifdef PC_MISALIGN_EN
    .pc_misaligned(pc_misaligned),
`endif
    .pc           (pc)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] imm;
    logic        s0;
    logic        br;
    logic        az;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one set of inputs just after a falling edge, leaving half a period
  // of setup before the sampling edge.
  task automatic drive(input logic rst, input logic [31:0] imm, input logic j,
                       input logic br, input logic az);
    @(negedge sysclk);
    reset     = rst;
    immediate = imm;
    s0        = j;
    branch    = br;
    alu_zero  = az;
  endtask

  task automatic edge_then_sample();
    @(posedge sysclk);
    #1;
  endtask

  task automatic add(input string n, input logic r, input logic [31:0] i, input logic j,
                     input logic b, input logic a, input logic [31:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.imm = i; v.s0 = j; v.br = b; v.az = a; v.exp_pc = e;
    vecs.push_back(v);
  endtask

  initial begin
    reset     = 1'b1;
    immediate = 32'h0;
    s0        = 1'b0;
    branch    = 1'b0;
    alu_zero  = 1'b0;

    //  name               rst  imm            s0 br az  expected pc
    add("reset_edge",      1, 32'h0000_0010, 0, 0, 0, 32'h0000_0000);
    add("first_seq",       0, 32'h0000_0010, 0, 0, 0, 32'h0000_0004);
    add("branch_0x10",     0, 32'h0000_0010, 0, 1, 1, 32'h0000_0014);
    add("branch_0x20_a",   0, 32'h0000_0020, 0, 1, 1, 32'h0000_0034);
    add("branch_0x20_b",   0, 32'h0000_0020, 0, 1, 1, 32'h0000_0054);
    add("br_not_taken",    0, 32'h0000_0020, 0, 1, 0, 32'h0000_0058);
    add("zero_no_branch",  0, 32'h0000_0020, 0, 0, 1, 32'h0000_005C);
    add("jump_wins",       0, 32'h0000_0101, 1, 1, 1, 32'h0000_0100);
    add("branch_neg8",     0, 32'hFFFF_FFF8, 0, 1, 1, 32'h0000_00F8);
    add("jump_top",        0, 32'hFFFF_FFFC, 1, 0, 0, 32'hFFFF_FFFC);
    add("seq_wrap",        0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000);
    add("jump_all_ones",   0, 32'hFFFF_FFFF, 1, 0, 0, 32'hFFFF_FFFE);
    add("seq_wrap_odd",    0, 32'h0000_0000, 0, 0, 0, 32'h0000_0002);
    add("branch_imm0",     0, 32'h0000_0000, 0, 1, 1, 32'h0000_0002);
    add("jump_aligned",    0, 32'h0000_0200, 1, 0, 0, 32'h0000_0200);

    // Reset acts immediately, before any clock edge.
    #1;
    check("reset_async_t0", pc, 32'h0);
`ifdef PC_MISALIGN_EN
    check("mis_reset", {31'b0, pc_misaligned}, 32'h0);
`endif

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].imm, vecs[k].s0, vecs[k].br, vecs[k].az);
      edge_then_sample();
      check(vecs[k].name, pc, vecs[k].exp_pc);
`ifdef PC_MISALIGN_EN
      check({vecs[k].name, "_mis"}, {31'b0, pc_misaligned}, {31'b0, |vecs[k].exp_pc[1:0]});
`endif
    end

    // Inputs changed between edges must not move pc; only the values present
    // at the edge count. pc is 0x200 here.
    @(negedge sysclk);
    s0        = 1'b1;
    immediate = 32'h0000_0500;
    #2;
    check("midcycle_jump_ignored", pc, 32'h0000_0200);
    s0        = 1'b0;
    branch    = 1'b1;
    alu_zero  = 1'b1;
    immediate = 32'h0000_0040;
    edge_then_sample();
    check("last_value_sampled", pc, 32'h0000_0240);

    // Reset asserted between edges clears pc at once, then holds it through
    // an edge even with a taken branch presented.
    @(negedge sysclk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_midrun", pc, 32'h0);
    edge_then_sample();
    check("reset_holds_on_edge", pc, 32'h0);

    // Release reset between edges: pc waits for the next rising edge.
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    #1;
    check("release_waits_edge", pc, 32'h0);
    edge_then_sample();
    check("release_first_step", pc, 32'h0000_0004);

`ifdef PC_MISALIGN_EN
    // Branch by 2 makes pc misaligned; sequential steps keep it misaligned;
    // an aligned jump clears the flag.
    drive(1'b0, 32'h0000_0002, 1'b0, 1'b1, 1'b1);
    edge_then_sample();
    check("mis_branch_pc", pc, 32'h0000_0006);
    check("mis_branch_flag", {31'b0, pc_misaligned}, 32'h1);
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    edge_then_sample();
    check("mis_seq_pc", pc, 32'h0000_000A);
    check("mis_seq_flag", {31'b0, pc_misaligned}, 32'h1);
    drive(1'b0, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
    edge_then_sample();
    check("mis_clear_pc", pc, 32'h0000_0040);
    check("mis_clear_flag", {31'b0, pc_misaligned}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the clock or the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
